// File: rtl/jtpopeye_rom_sched.sv
// Purpose: arbitrates CPU (byte) and object (32-bit) ROM reads onto one SDRAM read port, one-entry cache per requester.
// Latency: hits are combinational; a miss raises sdram_req 1 cycle after it appears, and the data hits the cycle after data_rdy.
// Backpressure: requesters hold cs/addr until *_ok; sdram_req is held until sdram_ack; a flush drops everything in flight.
module jtpopeye_rom_sched #(
    parameter int          CPU_AW     = 15,
    parameter int          OBJ_AW     = 13,
    parameter logic [21:0] CPU_OFFSET = 22'h00_0000,
    parameter logic [21:0] OBJ_OFFSET = 22'h00_4000
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loop_rst,
    input  logic              downloading,
    input  logic              cpu_cs,
    input  logic [CPU_AW-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_ok,
    input  logic              obj_cs,
    input  logic [OBJ_AW-1:0] obj_addr,
    output logic [31:0]       obj_data,
    output logic              obj_ok,
    output logic [21:0]       sdram_addr,
    output logic              sdram_req,
    input  logic              sdram_ack,
    input  logic [31:0]       data_read,
    input  logic              data_rdy,
    output logic              refresh_en
);

    localparam int CTW = CPU_AW - 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_WAIT_RDY = 2'd2;

    localparam logic SLOT_CPU = 1'b0;
    localparam logic SLOT_OBJ = 1'b1;

    logic [1:0]        state;
    logic              gnt_slot;
    logic              last_served;

    logic              cpu_valid;
    logic [CTW-1:0]    cpu_tag;
    logic [31:0]       cpu_word;
    logic [CTW-1:0]    fill_cpu_tag;

    logic              obj_valid;
    logic [OBJ_AW-1:0] obj_tag;
    logic [31:0]       obj_word;
    logic [OBJ_AW-1:0] fill_obj_tag;

    logic              flush;
    logic              req_block;
    logic [CTW-1:0]    cpu_addr_tag;
    logic              cpu_hit;
    logic              obj_hit;
    logic              cpu_miss;
    logic              obj_miss;
    logic              pick_cpu;
    logic [21:0]       cpu_req_addr;
    logic [21:0]       obj_req_addr;

    // Flush sources discard cache contents and any fill in flight; reset also
    // blocks new requests so the idle outputs show their reset values.
    assign flush        = loop_rst | downloading;
    assign req_block    = flush | ~rst_n;

    assign cpu_addr_tag = cpu_addr[CPU_AW-1:2];
    assign cpu_hit      = cpu_cs & cpu_valid & (cpu_tag == cpu_addr_tag);
    assign obj_hit      = obj_cs & obj_valid & (obj_tag == obj_addr);
    assign cpu_miss     = cpu_cs & ~cpu_hit & ~req_block;
    assign obj_miss     = obj_cs & ~obj_hit & ~req_block;

    assign cpu_ok       = cpu_hit & ~flush;
    assign obj_ok       = obj_hit & ~flush;
    assign cpu_data     = cpu_word[{cpu_addr[1:0], 3'b000} +: 8];
    assign obj_data     = obj_word;

    // When both slots miss, serve the one that was not served last so neither starves.
    assign pick_cpu     = cpu_miss & (~obj_miss | (last_served == SLOT_OBJ));

    // ROM words are 32 bits, SDRAM words 16 bits: a tag maps to two SDRAM words.
    assign cpu_req_addr = CPU_OFFSET + 22'({cpu_addr_tag, 1'b0});
    assign obj_req_addr = OBJ_OFFSET + 22'({obj_addr, 1'b0});

    assign refresh_en   = req_block | ((state == ST_IDLE) & ~cpu_miss & ~obj_miss);

    // Request FSM and cache fill; flush overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            gnt_slot     <= SLOT_CPU;
            last_served  <= SLOT_OBJ;
            cpu_valid    <= 1'b0;
            cpu_tag      <= '0;
            cpu_word     <= '0;
            fill_cpu_tag <= '0;
            obj_valid    <= 1'b0;
            obj_tag      <= '0;
            obj_word     <= '0;
            fill_obj_tag <= '0;
            sdram_addr   <= '0;
            sdram_req    <= 1'b0;
        end else if (flush) begin
            state        <= ST_IDLE;
            sdram_req    <= 1'b0;
            cpu_valid    <= 1'b0;
            obj_valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_miss | obj_miss) begin
                        if (pick_cpu) begin
                            gnt_slot     <= SLOT_CPU;
                            fill_cpu_tag <= cpu_addr_tag;
                            sdram_addr   <= cpu_req_addr;
                        end else begin
                            gnt_slot     <= SLOT_OBJ;
                            fill_obj_tag <= obj_addr;
                            sdram_addr   <= obj_req_addr;
                        end
                        sdram_req <= 1'b1;
                        state     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    // The fill lands under the tag latched at grant time, even
                    // if the requester has since moved on.
                    if (data_rdy) begin
                        if (gnt_slot == SLOT_CPU) begin
                            cpu_valid <= 1'b1;
                            cpu_tag   <= fill_cpu_tag;
                            cpu_word  <= data_read;
                        end else begin
                            obj_valid <= 1'b1;
                            obj_tag   <= fill_obj_tag;
                            obj_word  <= data_read;
                        end
                        last_served <= gnt_slot;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtpopeye_rom_sched.sv
// Purpose: directed bench for jtpopeye_rom_sched with a hand-driven SDRAM responder.
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled there as well.
// Backpressure: the SDRAM side acks and returns data after fixed directed delays.
module tb_jtpopeye_rom_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        loop_rst = 1'b0;
    logic        downloading = 1'b0;
    logic        cpu_cs = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic        obj_cs = 1'b0;
    logic [12:0] obj_addr = '0;
    logic [31:0] obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic [31:0] data_read = '0;
    logic        data_rdy = 1'b0;
    logic        refresh_en;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jtpopeye_rom_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .loop_rst    (loop_rst),
        .downloading (downloading),
        .cpu_cs      (cpu_cs),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ok      (cpu_ok),
        .obj_cs      (obj_cs),
        .obj_addr    (obj_addr),
        .obj_data    (obj_data),
        .obj_ok      (obj_ok),
        .sdram_addr  (sdram_addr),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .data_read   (data_read),
        .data_rdy    (data_rdy),
        .refresh_en  (refresh_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cpu_cs    = 1'b0;
        obj_cs    = 1'b0;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(sdram_req), 32'd1);
        check({tag, "_addr"}, 32'(sdram_addr), exp_addr);
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) tick();
        check("req_held", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("req_drop", 32'(sdram_req), 32'd0);
    endtask

    task automatic do_rdy(input int dly, input logic [31:0] d);
        repeat (dly) tick();
        data_read = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_cpu_ok", 32'(cpu_ok), 32'd0);
        check("rst_obj_ok", 32'(obj_ok), 32'd0);
        check("rst_cpu_data", 32'(cpu_data), 32'd0);
        check("rst_obj_data", obj_data, 32'd0);
        check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        check("rst_sdram_req", 32'(sdram_req), 32'd0);
        check("rst_refresh", 32'(refresh_en), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Cold CPU read at byte address 5
        cpu_cs = 1'b1;
        cpu_addr = 15'h0005;
        #1;
        check("s1_refresh_miss", 32'(refresh_en), 32'd0);
        check("s1_req_before", 32'(sdram_req), 32'd0);
        tick();
        check("s1_req_1cyc", 32'(sdram_req), 32'd1);
        check("s1_addr", 32'(sdram_addr), 32'h000002);
        do_ack(2);
        check("s1_refresh_wrdy", 32'(refresh_en), 32'd0);
        do_rdy(3, 32'hDDCCBBAA);
        check("s1_cpu_ok", 32'(cpu_ok), 32'd1);
        check("s1_cpu_data", 32'(cpu_data), 32'hBB);
        check("s1_refresh_hit", 32'(refresh_en), 32'd1);
        cpu_addr = 15'h0007;
        #1;
        check("s1_hit7_ok", 32'(cpu_ok), 32'd1);
        check("s1_hit7_data", 32'(cpu_data), 32'hDD);
        repeat (3) tick();
        check("s1_no_req", 32'(sdram_req), 32'd0);
        // cs low keeps the cache
        cpu_cs = 1'b0;
        #1;
        check("s1_cs_low_ok", 32'(cpu_ok), 32'd0);
        tick();
        cpu_cs = 1'b1;
        cpu_addr = 15'h0004;
        #1;
        check("s1_rehit_ok", 32'(cpu_ok), 32'd1);
        check("s1_rehit_data", 32'(cpu_data), 32'hAA);

        // Simultaneous misses and alternation
        do_reset();
        cpu_cs = 1'b1;
        cpu_addr = 15'h0020;
        obj_cs = 1'b1;
        obj_addr = 13'h0010;
        wait_req("s2a_cpu", 32'h000010);
        do_ack(1);
        do_rdy(1, 32'h11223344);
        check("s2a_cpu_ok", 32'(cpu_ok), 32'd1);
        check("s2a_cpu_data", 32'(cpu_data), 32'h44);
        check("s2a_obj_ok", 32'(obj_ok), 32'd0);
        wait_req("s2b_obj", 32'h004020);
        do_ack(1);
        do_rdy(1, 32'hCAFEF00D);
        check("s2b_obj_ok", 32'(obj_ok), 32'd1);
        check("s2b_obj_data", obj_data, 32'hCAFEF00D);
        cpu_addr = 15'h0040;
        obj_addr = 13'h0011;
        wait_req("s2c_cpu", 32'h000020);
        do_ack(1);
        do_rdy(1, 32'h99887766);
        cpu_addr = 15'h0084;
        wait_req("s2d_obj", 32'h004022);
        do_ack(1);
        do_rdy(1, 32'h12345678);
        check("s2d_obj_data", obj_data, 32'h12345678);
        wait_req("s2e_cpu", 32'h000042);
        do_ack(1);
        do_rdy(1, 32'h0F1E2D3C);
        check("s2e_cpu_ok", 32'(cpu_ok), 32'd1);
        check("s2e_cpu_data", 32'(cpu_data), 32'h3C);

        // Address moves during a fill
        do_reset();
        cpu_cs = 1'b1;
        cpu_addr = 15'h0004;
        wait_req("s3a", 32'h000002);
        do_ack(1);
        cpu_addr = 15'h0100;
        #1;
        check("s3_ok_moved", 32'(cpu_ok), 32'd0);
        do_rdy(2, 32'h01020304);
        check("s3_ok_after_fill", 32'(cpu_ok), 32'd0);
        wait_req("s3b", 32'h000080);
        do_ack(1);
        do_rdy(1, 32'h0A0B0C0D);
        check("s3_ok_final", 32'(cpu_ok), 32'd1);
        check("s3_data_final", 32'(cpu_data), 32'h0D);

        // Flush by downloading during WAIT_ACK
        do_reset();
        obj_cs = 1'b1;
        obj_addr = 13'h0005;
        wait_req("s4a_obj", 32'h00400A);
        do_ack(1);
        do_rdy(1, 32'hA5A5_5A5A);
        check("s4_obj_ok_pre", 32'(obj_ok), 32'd1);
        cpu_cs = 1'b1;
        cpu_addr = 15'h0008;
        wait_req("s4b_cpu", 32'h000004);
        tick();
        downloading = 1'b1;
        #1;
        check("s4_obj_ok_flush", 32'(obj_ok), 32'd0);
        check("s4_refresh_flush", 32'(refresh_en), 32'd1);
        tick();
        check("s4_req_flushed", 32'(sdram_req), 32'd0);
        check("s4_cpu_ok_flushed", 32'(cpu_ok), 32'd0);
        check("s4_obj_ok_flushed", 32'(obj_ok), 32'd0);
        downloading = 1'b0;
        data_read = 32'hDEADBEEF;
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        check("s4_rereq", 32'(sdram_req), 32'd1);
        check("s4_rereq_addr", 32'(sdram_addr), 32'h000004);
        check("s4_late_rdy_ok", 32'(cpu_ok), 32'd0);
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        check("s4_rdy_in_ack_ok", 32'(cpu_ok), 32'd0);
        do_ack(0);
        do_rdy(1, 32'h55667788);
        check("s4_cpu_ok", 32'(cpu_ok), 32'd1);
        check("s4_cpu_data", 32'(cpu_data), 32'h88);
        wait_req("s4c_obj", 32'h00400A);
        do_ack(1);
        do_rdy(1, 32'h600DF00D);
        check("s4_obj_data", obj_data, 32'h600DF00D);

        // refresh_en and asynchronous reset in WAIT_RDY
        do_reset();
        check("s5_refresh_idle", 32'(refresh_en), 32'd1);
        cpu_cs = 1'b1;
        cpu_addr = 15'h000C;
        wait_req("s5a", 32'h000006);
        check("s5_refresh_wack", 32'(refresh_en), 32'd0);
        do_ack(1);
        do_rdy(1, 32'hA1B2C3D4);
        check("s5_refresh_hit", 32'(refresh_en), 32'd1);
        cpu_addr = 15'h0010;
        wait_req("s5b", 32'h000008);
        do_ack(1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_arst_req", 32'(sdram_req), 32'd0);
        check("s5_arst_addr", 32'(sdram_addr), 32'd0);
        check("s5_arst_cpu_data", 32'(cpu_data), 32'd0);
        check("s5_arst_cpu_ok", 32'(cpu_ok), 32'd0);
        check("s5_arst_refresh", 32'(refresh_en), 32'd1);
        tick();
        rst_n = 1'b1;
        wait_req("s5c", 32'h000008);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
